// File: rtl/serial_rx_pkg.sv
// Shared types and sizing helpers for the serial receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_rx_pkg;

  // Receiver sequencing states; PARITY is only entered when parity is built in
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  // Default frame geometry: 16x oversampling, 8 data bits
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  // Width of the per-bit tick counter for a given oversample ratio
  function automatic int tick_width(input int os);
    return $clog2(os);
  endfunction

  // Tick index at the middle of a bit period (used to qualify the start bit)
  function automatic int mid_index(input int os);
    return os / 2 - 1;
  endfunction

  // Width of the data bit index (at least one bit)
  function automatic int idx_width(input int nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input, resets to 1 (idle line).
// Latency: 2 clk from input change to output change.
// Backpressure: none; free-running.
module serial_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages come out of reset at the idle level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_ctrl.sv
// Serial byte receiver: oversampled start/data/stop framing into a 1-entry valid/ready buffer.
// Latency: byte visible 1 clk after the tick that samples the stop bit (plus 2 clk input sync).
// Backpressure: buffer full and not consumed -> new byte dropped, sticky overrun set.
// Build option: define SERIAL_RX_PARITY_EN to add an even-parity bit between data and stop.
module serial_rx_ctrl
  import serial_rx_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = tick_width(OVERSAMPLE);
  localparam int BW = idx_width(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(mid_index(OVERSAMPLE));
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxs;
`ifdef SERIAL_RX_PARITY_EN
  logic                 par_acc;
  logic                 par_fail;
`endif

  serial_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rxs)
  );

  // Frame sequencer plus output buffer: all counting gated by sample_tick, handshake every clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_acc   <= 1'b0;
      par_fail  <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;

      // Consumer handshake; a same-cycle delivery below overrides the clear
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      if (sample_tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end

          START: begin
            if (tick_cnt == TICK_MID) begin
              if (rxs) begin
                // Line went back high before mid start bit: treat as a glitch
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_idx  <= '0;
`ifdef SERIAL_RX_PARITY_EN
                par_acc  <= 1'b0;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              // LSB arrives first, so shifting right leaves it at bit 0 after the last bit
              shreg    <= {rxs, shreg[DATA_BITS-1:1]};
              tick_cnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
              par_acc  <= par_acc ^ rxs;
`endif
              if (bit_idx == BIT_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_idx <= bit_idx + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

`ifdef SERIAL_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              // Even parity: data bits xor parity bit must be zero
              par_fail <= par_acc ^ rxs;
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
`endif

          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (!rxs) begin
                // Bad stop bit: drop byte and wait out a possible break condition
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
`ifdef SERIAL_RX_PARITY_EN
              end else if (par_fail) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
`endif
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end

          WAIT_HIGH: begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Bench for serial_rx_ctrl: directed frames, expected bytes queued, monitor pops on transfer.
// Latency: n/a.
// Backpressure: exercised via rx_ready.
module tb_serial_rx_ctrl;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       sample_tick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int vld_cycles = 0;
  int fe_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  serial_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .sample_tick (sample_tick),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: count valid cycles and frame errors, compare every transferred byte
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) fe_cnt++;
      if (rx_valid) begin
        vld_cycles++;
        if (rx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
          end else begin
            exp_b = exp_q.pop_front();
            check("rx_data", {24'h0, rx_data}, {24'h0, exp_b});
          end
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    clks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit(par);
`else
    if (par) begin end
`endif
    send_bit(stop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rx_in = 1'b1; sample_tick = 1'b1; rx_ready = 1'b1;
    #12;
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_data", {24'h0, rx_data}, 32'h0);
    check("rst_ferr", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    clks(20);

    // Clean frame 0xA5 with consumer ready
    vld_cycles = 0; fe_cnt = 0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, ^8'hA5, 1'b1);
    send_bit(1'b1);
    check("a5_vld_cycles", vld_cycles, 1);
    check("a5_ferr", fe_cnt, 0);
    check("a5_overrun", {31'h0, overrun}, 32'h0);

    // 4-clk low glitch on idle line
    vld_cycles = 0;
    rx_in = 1'b0;
    clks(4);
    rx_in = 1'b1;
    check("glitch_busy_start", {31'h0, busy}, 32'h1);
    clks(20);
    check("glitch_busy_end", {31'h0, busy}, 32'h0);
    check("glitch_no_vld", vld_cycles, 0);

    // 0x3C with bad stop, line held low, then recovery frame 0x55
    vld_cycles = 0; fe_cnt = 0;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    rx_in = 1'b0;
    clks(40);
    check("brk_ferr_once", fe_cnt, 1);
    check("brk_busy_held", {31'h0, busy}, 32'h1);
    check("brk_no_vld", vld_cycles, 0);
    rx_in = 1'b1;
    clks(16);
    check("brk_busy_release", {31'h0, busy}, 32'h0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, ^8'h55, 1'b1);
    send_bit(1'b1);
    check("brk_55_vld", vld_cycles, 1);

    // Overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1);
    send_bit(1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    send_bit(1'b1);
    check("ovr_valid", {31'h0, rx_valid}, 32'h1);
    check("ovr_data_held", {24'h0, rx_data}, 32'h11);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    exp_q.push_back(8'h11);
    rx_ready = 1'b1;
    clks(1);
    check("ovr_valid_cleared", {31'h0, rx_valid}, 32'h0);
    check("ovr_flag_cleared", {31'h0, overrun}, 32'h0);
    clks(4);

    // Reset during data bit 3 of 0xFF, then clean 0x81
    send_bit(1'b0);
    rx_in = 1'b1;
    clks(3 * OS + 8);
    check("mid_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #2;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_data", {24'h0, rx_data}, 32'h0);
    check("mid_rst_valid", {31'h0, rx_valid}, 32'h0);
    clks(2);
    reset = 1'b0;
    clks(8 + 4 * OS + OS);
    check("mid_idle_after", {31'h0, busy}, 32'h0);
    vld_cycles = 0;
    exp_q.push_back(8'h81);
    send_frame(8'h81, ^8'h81, 1'b1);
    send_bit(1'b1);
    check("mid_81_vld", vld_cycles, 1);

`ifdef SERIAL_RX_PARITY_EN
    // Parity: 0x07 has odd weight, so the even parity bit must be 1
    vld_cycles = 0; fe_cnt = 0;
    send_frame(8'h07, 1'b0, 1'b1);
    send_bit(1'b1);
    check("par_bad_ferr", fe_cnt, 1);
    check("par_bad_no_vld", vld_cycles, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    check("par_good_vld", vld_cycles, 1);
    check("par_good_ferr", fe_cnt, 1);
`endif

    // Drain: every queued byte must have been seen
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) clks(1);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
